int2float_pipe: RTL and testbench



---
 rtl/int2float_pkg.sv | 33 +++
 rtl/int2float_lod.sv | 25 ++
 rtl/int2float_pipe.sv | 141 ++++++++++++++
 tb/tb_int2float_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int2float_pkg.sv
// Shared definitions for the int2float_pipe converter.
//   exp_w / man_w / bias : field geometry of the IEEE format matching WIDTH
//   s2_rec_t             : normalise -> round/pack stage record, sized for the
//                          widest legal format (binary64); narrower formats
//                          use the low bits of p and mant.
package int2float_pkg;

  localparam int MAX_P_W   = 6;
  localparam int MAX_MAN_W = 52;

  function automatic int exp_w(input int width);
    return (width == 64) ? 11 : 8;
  endfunction

  function automatic int man_w(input int width);
    return width - 1 - exp_w(width);
  endfunction

  function automatic int bias(input int width);
    return (1 << (exp_w(width) - 1)) - 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic                 zero;
    logic [MAX_P_W-1:0]   p;
    logic [MAX_MAN_W-1:0] mant;
    logic                 g;
    logic                 s;
  } s2_rec_t;

endpackage

// File: rtl/int2float_lod.sv
// Combinational leading-one detector.
//   mag : unsigned operand
//   p   : index of the highest set bit (0 when mag is 0)
//   rem : mag with that leading one cleared (mag - 2^p)
module int2float_lod
  import int2float_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int P_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mag,
  output logic [P_W-1:0]   p,
  output logic [WIDTH-1:0] rem
);

  always_comb begin
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) p = P_W'(i);
    end
    rem    = mag;
    rem[p] = 1'b0;
  end

endmodule

// File: rtl/int2float_pipe.sv
// Pipelined integer to IEEE-754 converter, 3-cycle latency, 1 word/cycle.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake; in_data integer, in_signed mode
//   out_valid/out_ready   : output handshake
//   out_data              : {sign, exponent, mantissa}, WIDTH = 32 or 64 only
//   out_inexact           : result differs from the exact integer value
// Macro INT2FLOAT_RNE_EN selects round-to-nearest-even; without it the
// mantissa is truncated (round toward zero). out_inexact reports G|S in both.
module int2float_pipe
  import int2float_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_inexact
);

  localparam int EXP_W = exp_w(WIDTH);
  localparam int MAN_W = man_w(WIDTH);
  localparam int P_W   = $clog2(WIDTH);
  localparam logic [EXP_W-1:0] BIAS = EXP_W'(bias(WIDTH));

`ifdef INT2FLOAT_RNE_EN
  function automatic logic [MAN_W:0] round_mant(input logic [MAN_W-1:0] mant,
                                                input logic g, input logic s);
    return {1'b0, mant} + {{MAN_W{1'b0}}, g & (s | mant[0])};
  endfunction
`else
  function automatic logic [MAN_W:0] round_mant(input logic [MAN_W-1:0] mant);
    return {1'b0, mant};
  endfunction
`endif

  // Whole pipe freezes while the consumer refuses a result; bubbles stay put.
  logic stall;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // ---- S1: sign / absolute value -> p0 ----
  logic                    vld_p0;
  logic                    sign_p0;
  logic [WIDTH-1:0]        mag_p0;
  logic                    sign_d;

  assign sign_d = in_signed & in_data[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else if (!stall) vld_p0 <= in_valid;
  end

  // Signed minimum negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  always_ff @(posedge clk) begin
    if (!stall) begin
      sign_p0 <= sign_d;
      mag_p0  <= sign_d ? -in_data : in_data;
    end
  end

  // ---- S2: normalise -> p1 ----
  logic [P_W-1:0]   lod_p;
  logic [WIDTH-1:0] lod_rem;
  logic [WIDTH-1:0] aligned;
  s2_rec_t          rec_d;
  s2_rec_t          s2_p1;

  int2float_lod #(.WIDTH(WIDTH)) u_lod (
    .mag (mag_p0),
    .p   (lod_p),
    .rem (lod_rem)
  );

  // Shift the (cleared) leading one to the MSB; the bits below it are then
  // mantissa, guard and sticky in descending order.
  always_comb begin
    aligned                = lod_rem << (P_W'(WIDTH - 1) - lod_p);
    rec_d                  = '0;
    rec_d.valid            = vld_p0;
    rec_d.sign             = sign_p0;
    rec_d.zero             = (mag_p0 == '0);
    rec_d.p                = MAX_P_W'(lod_p);
    rec_d.mant[MAN_W-1:0]  = aligned[WIDTH-2 -: MAN_W];
    rec_d.g                = aligned[WIDTH-2-MAN_W];
    rec_d.s                = |aligned[WIDTH-3-MAN_W:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) s2_p1.valid <= 1'b0;
    else if (!stall) s2_p1 <= rec_d;
  end

  // ---- S3: round / pack -> p2 (output register) ----
  logic [MAN_W:0]   rnd;
  logic [EXP_W-1:0] exp_s3;
  logic [WIDTH-1:0] data_d;
  logic             inexact_d;
  logic             vld_p2;

  always_comb begin
`ifdef INT2FLOAT_RNE_EN
    rnd = round_mant(s2_p1.mant[MAN_W-1:0], s2_p1.g, s2_p1.s);
`else
    rnd = round_mant(s2_p1.mant[MAN_W-1:0]);
`endif
    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    exp_s3    = EXP_W'(s2_p1.p) + BIAS + EXP_W'(rnd[MAN_W]);
    data_d    = {s2_p1.sign, exp_s3, rnd[MAN_W-1:0]};
    inexact_d = s2_p1.g | s2_p1.s;
    if (s2_p1.zero) begin
      data_d    = '0;
      inexact_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2      <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else if (!stall) begin
      vld_p2      <= s2_p1.valid;
      out_data    <= data_d;
      out_inexact <= inexact_d;
    end
  end

  assign out_valid = vld_p2;

  // Bits that exist only for the widest format or are structurally zero.
  logic unused_bits;
  assign unused_bits = ^{aligned[WIDTH-1], s2_p1.mant, s2_p1.g, s2_p1.s};

endmodule

// File: tb/tb_int2float_pipe.sv
module tb_int2float_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid32, in_ready32, in_signed32, out_valid32, out_ready32, out_inexact32;
  logic [31:0] in_data32, out_data32;
  logic        in_valid64, in_ready64, in_signed64, out_valid64, out_ready64, out_inexact64;
  logic [63:0] in_data64, out_data64;

  int2float_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_signed(in_signed32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_data(out_data32), .out_inexact(out_inexact32)
  );

  int2float_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_data(in_data64), .in_signed(in_signed64), .out_valid(out_valid64),
    .out_ready(out_ready64), .out_data(out_data64), .out_inexact(out_inexact64)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_out32 = 0;
  int n_stall32 = 0;
  logic [64:0] q32[$];
  logic [64:0] q64[$];

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference conversion from plain integer arithmetic: {inexact, float}.
  function automatic logic [64:0] model(input int width, input logic [63:0] din, input logic sm);
    int man_w, bias_v, p, sh;
    logic neg, inx;
    logic [63:0] m, rem, q, r;
    logic [10:0] e;
    man_w  = (width == 32) ? 23 : 52;
    bias_v = (width == 32) ? 127 : 1023;
    if (width == 32) begin
      neg = sm & din[31];
      m   = neg ? {32'b0, -din[31:0]} : {32'b0, din[31:0]};
    end else begin
      neg = sm & din[63];
      m   = neg ? -din : din;
    end
    if (m == 64'd0) return '0;
    p = 0;
    while ((m >> (p + 1)) != 64'd0) p++;
    rem = m - (64'd1 << p);
    inx = 1'b0;
    if (p <= man_w) begin
      q = rem << (man_w - p);
    end else begin
      sh  = p - man_w;
      q   = rem >> sh;
      r   = rem - (q << sh);
      inx = (r != 64'd0);
`ifdef INT2FLOAT_RNE_EN
      if (r > (64'd1 << (sh - 1)) || (r == (64'd1 << (sh - 1)) && q[0])) q = q + 64'd1;
`endif
    end
    e = 11'(p + bias_v);
    if (q == (64'd1 << man_w)) begin
      q = 64'd0;
      e = e + 11'd1;
    end
    if (width == 32) return {inx, 32'b0, neg, e[7:0], q[22:0]};
    return {inx, neg, e, q[51:0]};
  endfunction

  // Scoreboard: checks every cycle an output is presented, including stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
      q64.delete();
    end else begin
      chk("in_ready32", 65'(in_ready32), 65'(!(out_valid32 && !out_ready32)));
      chk("in_ready64", 65'(in_ready64), 65'(!(out_valid64 && !out_ready64)));
      if (out_valid32 && !out_ready32) n_stall32++;
      if (out_valid32) begin
        if (q32.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_out32: got out_valid=1 with data %h expected no output", out_data32);
        end else begin
          chk("out32", {out_inexact32, 32'b0, out_data32}, q32[0]);
          if (out_ready32) begin
            void'(q32.pop_front());
            n_out32++;
          end
        end
      end
      if (out_valid64) begin
        if (q64.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_out64: got out_valid=1 with data %h expected no output", out_data64);
        end else begin
          chk("out64", {out_inexact64, out_data64}, q64[0]);
          if (out_ready64) void'(q64.pop_front());
        end
      end
      if (in_valid32 && in_ready32) q32.push_back(model(32, {32'b0, in_data32}, in_signed32));
      if (in_valid64 && in_ready64) q64.push_back(model(64, in_data64, in_signed64));
    end
  end

  task automatic send32(input logic [31:0] d, input logic s);
    int guard = 0;
    in_valid32 = 1'b1; in_data32 = d; in_signed32 = s;
    @(negedge clk);
    while (!in_ready32 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL send32_timeout: got in_ready=0 for 100 cycles expected acceptance");
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] d, input logic s);
    in_valid64 = 1'b1; in_data64 = d; in_signed64 = s;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
  endtask

  // Isolated conversion on an empty pipe: latency and literal result.
  task automatic single32(input string nm, input logic [31:0] d, input logic s,
                          input logic [31:0] exp_d, input logic exp_i);
    int lat = 0;
    chk({nm, "_model"}, model(32, {32'b0, d}, s), {exp_i, 32'b0, exp_d});
    send32(d, s);
    @(negedge clk);
    while (!out_valid32 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 65'(lat + 1), 65'd3);
    chk({nm, "_data"}, 65'(out_data32), 65'(exp_d));
    chk({nm, "_inexact"}, 65'(out_inexact32), 65'(exp_i));
    @(posedge clk); #1;
  endtask

  task automatic single64(input string nm, input logic [63:0] d, input logic s,
                          input logic [63:0] exp_d, input logic exp_i);
    int lat = 0;
    chk({nm, "_model"}, model(64, d, s), {exp_i, exp_d});
    send64(d, s);
    @(negedge clk);
    while (!out_valid64 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 65'(lat + 1), 65'd3);
    chk({nm, "_data"}, 65'(out_data64), 65'(exp_d));
    chk({nm, "_inexact"}, 65'(out_inexact64), 65'(exp_i));
    @(posedge clk); #1;
  endtask

  logic [31:0] stream_d [8] = '{32'd7, 32'hFFFFFFFD, 32'd16777219, 32'hFFFFFFFF,
                                32'd1000, 32'd0, 32'd123456789, 32'hFFFE7960};
  logic        stream_s [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int base, guard;
    rst_n = 1'b0;
    in_valid32 = 0; in_data32 = '0; in_signed32 = 0; out_ready32 = 1;
    in_valid64 = 0; in_data64 = '0; in_signed64 = 0; out_ready64 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 65'(out_valid32), 65'd0);
    chk("rst_out_data", 65'(out_data32), 65'd0);
    chk("rst_out_inexact", 65'(out_inexact32), 65'd0);
    chk("rst_in_ready", 65'(in_ready32), 65'd1);
    chk("rst_out_data64", 65'(out_data64), 65'd0);
    @(posedge clk); #1;

    single32("u80", 32'd80, 1'b0, 32'h42A00000, 1'b0);
    single32("u1", 32'd1, 1'b0, 32'h3F800000, 1'b0);
    // 300158478 = 2^28 + 991344*32 + 14: remainder below half, so rounds down.
    single32("u300158478", 32'd300158478, 1'b0, 32'h4D8F2070, 1'b1);
    single32("s_m1", 32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0);
    single32("s_m5", 32'hFFFFFFFB, 1'b1, 32'hC0A00000, 1'b0);
    single32("s_m8", 32'hFFFFFFF8, 1'b1, 32'hC1000000, 1'b0);
    single32("s_min", 32'h80000000, 1'b1, 32'hCF000000, 1'b0);
    single32("u_zero", 32'd0, 1'b0, 32'h00000000, 1'b0);
    single32("s_zero", 32'd0, 1'b1, 32'h00000000, 1'b0);
`ifdef INT2FLOAT_RNE_EN
    single32("u_allones", 32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1);
    single32("u16777219", 32'd16777219, 1'b0, 32'h4B800002, 1'b1);
`else
    single32("u_allones", 32'hFFFFFFFF, 1'b0, 32'h4F7FFFFF, 1'b1);
    single32("u16777219", 32'd16777219, 1'b0, 32'h4B800001, 1'b1);
`endif

    // Back-to-back stream with a 4-cycle consumer stall in the middle.
    base = n_out32;
    fork
      begin
        for (int i = 0; i < 8; i++) send32(stream_d[i], stream_s[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready32 = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready32 = 1'b1;
      end
    join
    guard = 0;
    while (q32.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("stream_count", 65'(n_out32 - base), 65'd8);
    chk("stream_stalled", 65'(n_stall32 >= 4), 65'd1);

    // Reset with three words in flight discards them all.
    send32(32'd11, 1'b0);
    send32(32'd22, 1'b0);
    send32(32'd33, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_valid", 65'(out_valid32), 65'd0);
    end
    @(posedge clk); #1;

    single64("w64_u80", 64'd80, 1'b0, 64'h4054000000000000, 1'b0);
    single64("w64_s_m1", 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hBFF0000000000000, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
